// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction loader: FSM state encoding, the
// default end-of-program word and the number of bytes per instruction word.
// Optional feature macro used by the loader: LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
package loader_pkg;

    localparam int NB_DATA_DEF    = 32;
    localparam int NB_BYTE_DEF    = 8;
    localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;

    localparam logic [NB_DATA_DEF-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    // CHECK is only reachable when the checksum feature is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Assembles accepted bytes into a big-endian word (first byte ends up in the
// MSB) and latches the finished word once the last byte of a word arrives.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high reset
//   i_clear      synchronous clear of the shift register and byte counter
//   i_accept     i_byte is taken this cycle
//   i_byte       incoming byte
//   o_word       last completed word (held until the next word completes)
//   o_word_ready pulse: the byte accepted this cycle completes a word
// ---------------------------------------------------------------------------
module byte_packer
    import loader_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_accept,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic [NB_DATA-1:0] o_word,
    output logic               o_word_ready
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [NB_DATA-1:0] word_q,  word_d;
    logic [1:0]         count_q, count_d;

    // Shift in accepted bytes; on the last byte of a word, copy the complete
    // word into a separate holding register so the write data stays stable
    // while the next word is already being shifted in.
    always_comb begin
        shift_d      = shift_q;
        count_d      = count_q;
        word_d       = word_q;
        o_word_ready = 1'b0;
        if (i_clear) begin
            shift_d = '0;
            count_d = '0;
        end else if (i_accept) begin
            shift_d = {shift_q[NB_DATA-NB_BYTE-1:0], i_byte};
            count_d = count_q + 2'd1;
            if (count_q == LAST_BYTE) begin
                o_word_ready = 1'b1;
                word_d       = shift_d;
            end
        end
    end

    // Packer state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            word_q  <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    assign o_word = word_q;

endmodule

// File: rtl/instruction_loader.sv
// ---------------------------------------------------------------------------
// instruction_loader
// Receives a serial byte stream, packs it into big-endian instruction words
// and writes them to consecutive instruction-memory word addresses until the
// HALT word is written (done) or memory runs out (overflow).
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, a running XOR of every accepted byte is kept and one extra
//   byte after HALT is compared against it (CHECK state, o_checksum_err).
//   When undefined, HALT goes straight to DONE and o_checksum_err is 0.
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   i_start          pulse: begin a new load (ignored while busy)
//   i_rx_data        received byte
//   i_rx_valid       i_rx_data valid this cycle
//   o_wr_en          instruction memory write strobe (WRITE state only)
//   o_wr_addr        word address of the write (held afterwards)
//   o_wr_data        instruction word written (held afterwards)
//   o_busy           load in progress (RECV/WRITE/CHECK)
//   o_done           HALT written
//   o_overflow       memory full before HALT
//   o_word_count     words written including HALT
//   o_checksum_err   checksum mismatch
// ---------------------------------------------------------------------------
module instruction_loader
    import loader_pkg::*;
#(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_BYTE   = 8,
    parameter int                 NB_ADDR   = 10,
    parameter logic [NB_DATA-1:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_start,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_wr_en,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic [NB_DATA-1:0] o_wr_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow,
    output logic [NB_ADDR:0]   o_word_count,
    output logic               o_checksum_err
);

    localparam logic [NB_ADDR-1:0] ADDR_ONE  = 1;
    localparam logic [NB_ADDR-1:0] ADDR_LAST = '1;
    localparam logic [NB_ADDR:0]   CNT_ONE   = 1;

    state_t state_q, state_d;

    logic [NB_ADDR-1:0] addr_q,    addr_d;
    logic [NB_ADDR-1:0] wr_addr_q, wr_addr_d;
    logic [NB_ADDR:0]   count_q,   count_d;
    logic               done_q,    done_d;
    logic               ovf_q,     ovf_d;

`ifdef LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0] xor_q,     xor_d;
    logic               cerr_q,    cerr_d;
`endif

    logic               pk_clear;
    logic               pk_accept;
    logic               pk_ready;
    logic [NB_DATA-1:0] pk_word;
    logic               is_halt;
    logic               at_last_addr;
    logic               write_continue;

    byte_packer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_byte_packer (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (pk_clear),
        .i_accept     (pk_accept),
        .i_byte       (i_rx_data),
        .o_word       (pk_word),
        .o_word_ready (pk_ready)
    );

    // In WRITE the packer still holds the word being written, so the next
    // state can be decided from it. A byte arriving during WRITE is only kept
    // when the load carries on, which lets bytes stream back-to-back.
    assign is_halt        = (pk_word == HALT_WORD);
    assign at_last_addr   = (addr_q == ADDR_LAST);
    assign write_continue = !is_halt && !at_last_addr;
    assign pk_accept      = i_rx_valid &&
                            ((state_q == ST_RECV) ||
                             ((state_q == ST_WRITE) && write_continue));

    // Next-state logic: start handling, word completion, write outcome and
    // (when compiled in) the checksum comparison.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        count_d   = count_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        pk_clear  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        xor_d     = xor_q;
        cerr_d    = cerr_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    state_d  = ST_RECV;
                    addr_d   = '0;
                    count_d  = '0;
                    done_d   = 1'b0;
                    ovf_d    = 1'b0;
                    pk_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    xor_d    = '0;
                    cerr_d   = 1'b0;
`endif
                end
            end
            ST_RECV: begin
                if (pk_ready) begin
                    state_d   = ST_WRITE;
                    wr_addr_d = addr_q;
                end
            end
            ST_WRITE: begin
                count_d = count_q + CNT_ONE;
                if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
                    done_d  = 1'b1;
`endif
                end else if (at_last_addr) begin
                    state_d = ST_ERROR;
                    ovf_d   = 1'b1;
                end else begin
                    state_d = ST_RECV;
                    addr_d  = addr_q + ADDR_ONE;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (i_rx_valid) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    cerr_d  = (i_rx_data != xor_q);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef LOADER_CHECKSUM_EN
        if (pk_accept) begin
            xor_d = xor_q ^ i_rx_data;
        end
`endif
    end

    // State, address, counter and status flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wr_addr_q <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q     <= '0;
            cerr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            count_q   <= count_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
            cerr_q    <= cerr_d;
`endif
        end
    end

    assign o_wr_en      = (state_q == ST_WRITE);
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = pk_word;
    assign o_busy       = (state_q == ST_RECV) || (state_q == ST_WRITE) ||
                          (state_q == ST_CHECK);
    assign o_done       = done_q;
    assign o_overflow   = ovf_q;
    assign o_word_count = count_q;
`ifdef LOADER_CHECKSUM_EN
    assign o_checksum_err = cerr_q;
`else
    assign o_checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// ---------------------------------------------------------------------------
// tb_instruction_loader
// Directed bench for instruction_loader with a small memory (NB_ADDR=2) so
// the overflow boundary is reachable. Expected memory writes are queued by
// the stimulus and checked by an independent write monitor; status outputs
// are checked directly after each scenario.
// ---------------------------------------------------------------------------
module tb_instruction_loader;

    localparam int NB_DATA = 32;
    localparam int NB_BYTE = 8;
    localparam int NB_ADDR = 2;

    logic               clock;
    logic               reset;
    logic               i_start;
    logic [NB_BYTE-1:0] i_rx_data;
    logic               i_rx_valid;
    logic               o_wr_en;
    logic [NB_ADDR-1:0] o_wr_addr;
    logic [NB_DATA-1:0] o_wr_data;
    logic               o_busy;
    logic               o_done;
    logic               o_overflow;
    logic [NB_ADDR:0]   o_word_count;
    logic               o_checksum_err;

    int total = 0;
    int bad   = 0;

    logic [NB_ADDR-1:0] exp_addr_q[$];
    logic [NB_DATA-1:0] exp_data_q[$];

    instruction_loader #(
        .NB_DATA   (NB_DATA),
        .NB_BYTE   (NB_BYTE),
        .NB_ADDR   (NB_ADDR),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .i_start        (i_start),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_wr_en        (o_wr_en),
        .o_wr_addr      (o_wr_addr),
        .o_wr_data      (o_wr_data),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_overflow     (o_overflow),
        .o_word_count   (o_word_count),
        .o_checksum_err (o_checksum_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write monitor: every memory write must match the oldest queued
    // expectation; a write with nothing queued is itself an error.
    always @(negedge clock) begin
        if (!reset && o_wr_en) begin
            total++;
            if (exp_addr_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_write: got addr=%0d data=%08h, expected no write",
                         o_wr_addr, o_wr_data);
            end else begin
                logic [NB_ADDR-1:0] ea;
                logic [NB_DATA-1:0] ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (o_wr_addr !== ea || o_wr_data !== ed) begin
                    bad++;
                    $display("[TB] FAIL mem_write: got addr=%0d data=%08h, expected addr=%0d data=%08h",
                             o_wr_addr, o_wr_data, ea, ed);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, starting just after a rising edge.
    task automatic applyStimulus(input logic start, input logic valid,
                                 input logic [7:0] data);
        i_start    = start;
        i_rx_valid = valid;
        i_rx_data  = data;
        @(posedge clock);
        #1;
        i_start    = 1'b0;
        i_rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b0, 1'b1, b);
    endtask

    task automatic expectWrite(input logic [NB_ADDR-1:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Four bytes back-to-back, MSB first.
    task automatic sendWord(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            logic [31:0] tmp;
            tmp = w >> (8 * i);
            sendByte(tmp[7:0]);
        end
    endtask

    // Close a load after the HALT word: with the checksum feature the extra
    // byte is sent; then done and checksum status are verified.
    task automatic finishLoad(input logic [7:0] csum, input logic exp_err,
                              input int exp_count);
        idle(1);
`ifdef LOADER_CHECKSUM_EN
        checkOutput("check_busy", {31'd0, o_busy}, 32'd1);
        sendByte(csum);
`else
        csum = csum;
        exp_err = 1'b0;
`endif
        idle(1);
        checkOutput("done", {31'd0, o_done}, 32'd1);
        checkOutput("done_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("done_count", {29'd0, o_word_count}, exp_count);
        checkOutput("checksum_err", {31'd0, o_checksum_err}, {31'd0, exp_err});
    endtask

    initial begin
        reset      = 1'b1;
        i_start    = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        repeat (2) @(posedge clock);
        #1;

        // Reset state.
        checkOutput("rst_wr_en", {31'd0, o_wr_en}, 32'd0);
        checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("rst_done", {31'd0, o_done}, 32'd0);
        checkOutput("rst_overflow", {31'd0, o_overflow}, 32'd0);
        checkOutput("rst_count", {29'd0, o_word_count}, 32'd0);
        checkOutput("rst_wr_data", o_wr_data, 32'd0);
        reset = 1'b0;
        idle(1);

        // Basic program: one instruction plus HALT, bytes with gaps.
        $display("[TB] basic load");
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("start_busy", {31'd0, o_busy}, 32'd1);
        expectWrite(2'd0, 32'h2001_0005);
        sendByte(8'h20); idle(1);
        sendByte(8'h01); sendByte(8'h00); idle(2);
        sendByte(8'h05);
        idle(2);
        expectWrite(2'd1, 32'hFFFF_FFFF);
        sendWord(32'hFFFF_FFFF);
        finishLoad(8'h24, 1'b0, 2);

        // Back-to-back bytes: byte arriving in the WRITE cycle must be kept.
        $display("[TB] back-to-back stream");
        applyStimulus(1'b1, 1'b0, 8'h00);
        expectWrite(2'd0, 32'hAABB_CCDD);
        expectWrite(2'd1, 32'h1122_3344);
        sendWord(32'hAABB_CCDD);
        sendWord(32'h1122_3344);
        idle(2);
        checkOutput("b2b_count", {29'd0, o_word_count}, 32'd2);
        checkOutput("b2b_busy", {31'd0, o_busy}, 32'd1);
        expectWrite(2'd2, 32'hFFFF_FFFF);
        sendWord(32'hFFFF_FFFF);
        finishLoad(8'h44, 1'b0, 3);

        // Overflow: five plain words into a four-word memory.
        $display("[TB] overflow");
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("restart_done_clr", {31'd0, o_done}, 32'd0);
        expectWrite(2'd0, 32'h0102_0304);
        expectWrite(2'd1, 32'h0506_0708);
        expectWrite(2'd2, 32'h090A_0B0C);
        expectWrite(2'd3, 32'h0D0E_0F10);
        sendWord(32'h0102_0304);
        sendWord(32'h0506_0708);
        sendWord(32'h090A_0B0C);
        sendWord(32'h0D0E_0F10);
        sendWord(32'h1112_1314);
        idle(3);
        checkOutput("ovf_flag", {31'd0, o_overflow}, 32'd1);
        checkOutput("ovf_done", {31'd0, o_done}, 32'd0);
        checkOutput("ovf_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("ovf_count", {29'd0, o_word_count}, 32'd4);
        checkOutput("ovf_addr_held", {30'd0, o_wr_addr}, 32'd3);

        // Bytes before start, start with a byte, start pulsed mid-word.
        $display("[TB] start handling");
        sendByte(8'h77); sendByte(8'h88);
        checkOutput("prestart_busy", {31'd0, o_busy}, 32'd0);
        applyStimulus(1'b1, 1'b1, 8'h99);
        checkOutput("restart_ovf_clr", {31'd0, o_overflow}, 32'd0);
        expectWrite(2'd0, 32'hDEAD_BEEF);
        sendByte(8'hDE); sendByte(8'hAD);
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendByte(8'hBE); sendByte(8'hEF);
        idle(2);
        checkOutput("midstart_count", {29'd0, o_word_count}, 32'd1);

        // Reset in the middle of a word.
        $display("[TB] reset mid-load");
        sendByte(8'h55); sendByte(8'h66);
        reset = 1'b1;
        idle(1);
        checkOutput("midrst_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("midrst_count", {29'd0, o_word_count}, 32'd0);
        reset = 1'b0;
        idle(1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        expectWrite(2'd0, 32'h0A0B_0C0D);
        expectWrite(2'd1, 32'hFFFF_FFFF);
        sendWord(32'h0A0B_0C0D);
        idle(1);
        sendWord(32'hFFFF_FFFF);
        finishLoad(8'h00, 1'b0, 2);

`ifdef LOADER_CHECKSUM_EN
        // Checksum good and bad: 12^34^56^78 = 08, HALT contributes 00.
        $display("[TB] checksum");
        applyStimulus(1'b1, 1'b0, 8'h00);
        expectWrite(2'd0, 32'h1234_5678);
        expectWrite(2'd1, 32'hFFFF_FFFF);
        sendWord(32'h1234_5678);
        sendWord(32'hFFFF_FFFF);
        idle(1);
        checkOutput("check_not_done", {31'd0, o_done}, 32'd0);
        finishLoad(8'h08, 1'b0, 2);

        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("restart_cerr_clr", {31'd0, o_checksum_err}, 32'd0);
        expectWrite(2'd0, 32'h1234_5678);
        expectWrite(2'd1, 32'hFFFF_FFFF);
        sendWord(32'h1234_5678);
        sendWord(32'hFFFF_FFFF);
        finishLoad(8'h09, 1'b1, 2);
`endif

        idle(2);
        checkOutput("scoreboard_drained", exp_addr_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
